// File: rtl/fr_adder_pkg.sv
// Shared widths and the generate/propagate pair type for the MAC mantissa adder.
package fr_adder_pkg;

  localparam int FR_MANT_W     = 24;
  localparam int FR_CLA_W      = 25;
  localparam int FR_PFX_LEVELS = 5;
  localparam int FR_PFX_MIDLVL = 3;

  typedef struct packed {
    logic [FR_CLA_W-1:0] g;
    logic [FR_CLA_W-1:0] p;
  } fr_gp_t;

endpackage

// File: rtl/fr_adder_prefix_if.sv
// Operand/result bundle between the adder prepare stage and the prefix/sum stage.
interface fr_adder_prefix_if;
  import fr_adder_pkg::*;

  logic                in_valid;
  logic                in_out_sign;
  logic [FR_CLA_W-1:0] G0;
  logic [FR_CLA_W-1:0] P0;
  logic                out_valid;
  logic                out_sign;
  logic [FR_CLA_W-1:0] out_sum;

  modport master (
    output in_valid, in_out_sign, G0, P0,
    input  out_valid, out_sign, out_sum
  );

  modport slave (
    input  in_valid, in_out_sign, G0, P0,
    output out_valid, out_sign, out_sum
  );

endinterface

// File: rtl/fr_prefix_cell.sv
// Kogge-Stone black cell: merges a high group (gh, ph) with the lower group (gl, pl).
module fr_prefix_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);

  assign g = gh | (ph & gl);
  assign p = ph & pl;

endmodule

// File: rtl/fr_adder_prefix.sv
// 25-bit Kogge-Stone carry network plus sum XOR and output register, stallable by hold.
// FR_ADDER_PREFIX_MIDREG_EN adds a pipeline register after prefix level 3 (latency 2 instead of 1).
module fr_adder_prefix
  import fr_adder_pkg::*;
(
  input logic              clock,
  input logic              resetn,
  input logic              hold,
  fr_adder_prefix_if.slave bus
);

  fr_gp_t               mid_gp;
  logic [FR_MANT_W:1]   mid_p0;
  logic                 mid_sign;
  logic                 mid_valid;
  logic [FR_CLA_W-1:0]  gg;
  logic [FR_CLA_W-1:0]  sum_next;
  logic                 out_valid_reg;
  logic                 out_sign_reg;
  logic [FR_CLA_W-1:0]  out_sum_reg;
  logic                 unused_p;

  genvar gi, gj;

  generate
    for (gi = 0; gi < FR_PFX_LEVELS; gi++) begin : g_lvl
      localparam int DIST = 1 << gi;
      logic [FR_CLA_W-1:0] g_i, p_i, g_o, p_o;

      // The level after the mid point always reads the mid stage, registered or not.
      if (gi == 0) begin : g_src
        assign g_i = bus.G0;
        assign p_i = bus.P0;
      end else if (gi == FR_PFX_MIDLVL) begin : g_src
        assign g_i = mid_gp.g;
        assign p_i = mid_gp.p;
      end else begin : g_src
        assign g_i = g_lvl[gi-1].g_o;
        assign p_i = g_lvl[gi-1].p_o;
      end

      for (gj = 0; gj < FR_CLA_W; gj++) begin : g_pos
        if (gj < DIST) begin : g_pass
          assign g_o[gj] = g_i[gj];
          assign p_o[gj] = p_i[gj];
        end else begin : g_cell
          fr_prefix_cell u_cell (
            .gh (g_i[gj]),
            .ph (p_i[gj]),
            .gl (g_i[gj-DIST]),
            .pl (p_i[gj-DIST]),
            .g  (g_o[gj]),
            .p  (p_o[gj])
          );
        end
      end
    end
  endgenerate

`ifdef FR_ADDER_PREFIX_MIDREG_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mid_gp    <= '0;
      mid_p0    <= '0;
      mid_sign  <= 1'b0;
      mid_valid <= 1'b0;
    end else if (!hold) begin
      mid_gp    <= '{g: g_lvl[FR_PFX_MIDLVL-1].g_o, p: g_lvl[FR_PFX_MIDLVL-1].p_o};
      mid_p0    <= bus.P0[FR_MANT_W:1];
      mid_sign  <= bus.in_out_sign;
      mid_valid <= bus.in_valid;
    end
  end
`else
  assign mid_gp    = '{g: g_lvl[FR_PFX_MIDLVL-1].g_o, p: g_lvl[FR_PFX_MIDLVL-1].p_o};
  assign mid_p0    = bus.P0[FR_MANT_W:1];
  assign mid_sign  = bus.in_out_sign;
  assign mid_valid = bus.in_valid;
`endif

  // The final group propagate is not needed; only generates become carries.
  assign unused_p = ^g_lvl[FR_PFX_LEVELS-1].p_o;
  assign gg       = g_lvl[FR_PFX_LEVELS-1].g_o;
  assign sum_next = {gg[FR_CLA_W-1], mid_p0 ^ gg[FR_MANT_W-1:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      out_sign_reg  <= 1'b0;
      out_sum_reg   <= '0;
    end else if (!hold) begin
      out_valid_reg <= mid_valid;
      out_sign_reg  <= mid_sign;
      out_sum_reg   <= sum_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_sign  = out_sign_reg;
  assign bus.out_sum   = out_sum_reg;

endmodule

// File: tb/tb_fr_adder_prefix.sv
// Random and directed bench for fr_adder_prefix; expected results are plain integer sums.
module tb_fr_adder_prefix;

`ifdef FR_ADDER_PREFIX_MIDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [24:0] sum;
    logic        sign;
    int          due;
  } exp_t;

  logic clock;
  logic resetn;
  logic hold;
  int   total;
  int   bad;
  int   tick;
  exp_t q[$];

  fr_adder_prefix_if bus ();

  fr_adder_prefix dut (
    .clock  (clock),
    .resetn (resetn),
    .hold   (hold),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  // One clock: drive at negedge, DUT samples at posedge, check at the next negedge.
  task automatic step(input bit v, input bit h, input logic [23:0] a, input logic [23:0] b,
                      input bit s);
    exp_t e;
    hold            = h;
    bus.in_valid    = v;
    bus.in_out_sign = s;
    bus.G0          = {a & b, 1'b0};
    bus.P0          = {a ^ b, 1'b0};
    @(posedge clock);
    if (!h && resetn && v) begin
      e.sum  = {1'b0, a} + {1'b0, b};
      e.sign = s;
      e.due  = tick + LAT;
      q.push_back(e);
    end
    if (!h) tick++;
    @(negedge clock);
    if (!h) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check_eq("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check_eq("sum", 32'(bus.out_sum), 32'(e.sum));
          check_eq("sign", 32'(bus.out_sign), 32'(e.sign));
          check_eq("latency", 32'(tick), 32'(e.due));
          $display("txn tick=%0d sum=%07h sign=%0d", tick, bus.out_sum, bus.out_sign);
        end
      end else if (q.size() > 0 && q[0].due <= tick) begin
        check_eq("missing_valid", 32'(bus.out_valid), 32'd1);
        void'(q.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
  endtask

  initial begin
    logic [23:0] ra;
    logic [23:0] rb;
    total           = 0;
    bad             = 0;
    tick            = 0;
    resetn          = 1'b0;
    hold            = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_out_sign = 1'b0;
    bus.G0          = '0;
    bus.P0          = '0;
    repeat (2) @(negedge clock);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_sign", 32'(bus.out_sign), 32'd0);
    check_eq("rst_sum", 32'(bus.out_sum), 32'd0);
    resetn = 1'b1;

    // Carry ripple, MSB overflow, no carries.
    step(1'b1, 1'b0, 24'hFFFFFF, 24'h000001, 1'b0);
    step(1'b1, 1'b0, 24'h800000, 24'h800000, 1'b1);
    step(1'b1, 1'b0, 24'h123456, 24'h654321, 1'b0);
    idle(LAT + 1);

    // Stream of four with a three-cycle hold in the middle.
    step(1'b1, 1'b0, 24'h00A5A5, 24'h5A5A00, 1'b1);
    step(1'b1, 1'b0, 24'hFFFF00, 24'h0001FF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'hDEAD00, 24'h00BEEF, 1'b1);
    step(1'b1, 1'b0, 24'h7FFFFF, 24'h7FFFFF, 1'b1);
    step(1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0);
    idle(LAT + 1);

    // Asynchronous reset with operands in flight.
    step(1'b1, 1'b0, 24'h111111, 24'h222222, 1'b1);
    step(1'b1, 1'b0, 24'h333333, 24'h444444, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_sign", 32'(bus.out_sign), 32'd0);
    check_eq("midrst_sum", 32'(bus.out_sum), 32'd0);
    q.delete();
    @(negedge clock);
    step(1'b1, 1'b0, 24'h555555, 24'h666666, 1'b1);
    resetn = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
      check_eq("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end

    // Random operands with random bubbles and stalls.
    for (int i = 0; i < 10000; i++) begin
      ra = 24'($urandom());
      rb = 24'($urandom());
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, ra, rb, 1'($urandom()));
    end
    idle(LAT + 2);
    check_eq("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
